gmux_switch: RTL

GMUX_SWITCH -- requirements
Module: gmux_switch

---
 rtl/gmux_pkg.sv | 19 +
 rtl/gmux_sel.sv | 41 ++++
 rtl/gmux_switch.sv | 119 +++++++++++
 3 files changed

// File: rtl/gmux_pkg.sv
// Shared definitions for the glitch-free source multiplexer: FSM encoding,
// legal parameter ranges and the break counter width.
package gmux_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_BREAK = 2'd1,
    ST_MAKE  = 2'd2
  } gmux_state_e;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 8;
  localparam int GAP_MIN = 1;
  localparam int GAP_MAX = 15;

  // Wide enough to hold GAP_MAX.
  localparam int CNT_W = 4;

endpackage

// File: rtl/gmux_sel.sv
// Combinational gated source selector: picks one of NCH sources (channel 0
// optionally taken from the pad input) and forces the result low while the
// enable is clear. No register stage on this path.
module gmux_sel
  import gmux_pkg::*;
#(
  parameter int    NCH  = 4,
  parameter string MODE = "IP",
  localparam int   SELW = $clog2(NCH)
) (
  input  logic            ip_i,
  input  logic [NCH-1:0]  ic_i,
  input  logic [SELW-1:0] sel_i,
  input  logic            en_i,
  output logic            iz_o
);

  // Pad the source vector to a power of two so any select value indexes a
  // real bit; unused slots read as 0.
  localparam int NSRC = 1 << SELW;

  logic [NSRC-1:0] src;

  if (NCH > NCH_MAX) begin : g_bad_nch
    $error("gmux_sel: NCH=%0d exceeds %0d", NCH, NCH_MAX);
  end

  // Channel 0 is the pad in "IP" mode, otherwise the internal source.
  assign src[0] = (MODE == "IP") ? ip_i : ic_i[0];

  for (genvar gi = 1; gi < NSRC; gi++) begin : g_src
    if (gi < NCH) begin : g_used
      assign src[gi] = ic_i[gi];
    end else begin : g_pad
      assign src[gi] = 1'b0;
    end
  end

  assign iz_o = en_i & src[sel_i];

endmodule

// File: rtl/gmux_switch.sv
// Break-before-make source switch. A new legal request in RUN opens the
// output for GAP cycles (BREAK), then commits the new channel (MAKE) and
// returns to RUN. Requests arriving mid-switch are ignored; illegal
// requests only pulse ERR.
module gmux_switch
  import gmux_pkg::*;
#(
  parameter int    NCH  = 4,
  parameter int    GAP  = 2,
  parameter string MODE = "IP",
  localparam int   SELW = $clog2(NCH)
) (
  input  logic            QCK,
  input  logic            QRT,
  input  logic            IP,
  input  logic [NCH-1:0]  IC,
  input  logic [SELW-1:0] IS,
  output logic            IZ,
  output logic [SELW-1:0] ACT,
  output logic            BUSY,
  output logic            ERR
);

  if ((NCH < NCH_MIN) || (NCH > NCH_MAX)) begin : g_bad_nch
    $error("gmux_switch: NCH=%0d outside %0d..%0d", NCH, NCH_MIN, NCH_MAX);
  end
  if ((GAP < GAP_MIN) || (GAP > GAP_MAX)) begin : g_bad_gap
    $error("gmux_switch: GAP=%0d outside %0d..%0d", GAP, GAP_MIN, GAP_MAX);
  end
  if ((MODE != "IP") && (MODE != "IC")) begin : g_bad_mode
    $error("gmux_switch: MODE must be \"IP\" or \"IC\"");
  end

  localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP);
  localparam logic [SELW:0]    NCH_LIM = (SELW + 1)'(NCH);

  gmux_state_e      state_q, state_d;
  logic [SELW-1:0]  act_q, act_d;
  logic [SELW-1:0]  pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic             is_legal;

  // Select width may exceed the channel count (e.g. NCH=3); flag the gap.
  assign is_legal = ({1'b0, IS} < NCH_LIM);

  // Next-state logic: start a switch in RUN, count the break, commit in MAKE.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    err_d   = ~is_legal;
    case (state_q)
      ST_RUN: begin
        if (is_legal && (IS != act_q)) begin
          pend_d  = IS;
          en_d    = 1'b0;
          cnt_d   = GAP_CNT;
          state_d = ST_BREAK;
        end
      end
      ST_BREAK: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Leaving when the count hits zero gives exactly GAP gated cycles.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          act_d   = pend_q;
          en_d    = 1'b1;
          state_d = ST_MAKE;
        end
      end
      ST_MAKE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        en_d    = 1'b1;
      end
    endcase
  end

  // State registers; reset wins over any pending switch or request.
  always_ff @(posedge QCK) begin
    if (QRT) begin
      state_q <= ST_RUN;
      act_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      err_q   <= err_d;
    end
  end

  gmux_sel #(
    .NCH  (NCH),
    .MODE (MODE)
  ) u_sel (
    .ip_i  (IP),
    .ic_i  (IC),
    .sel_i (act_q),
    .en_i  (en_q),
    .iz_o  (IZ)
  );

  assign ACT  = act_q;
  assign BUSY = (state_q != ST_RUN);
  assign ERR  = err_q;

endmodule
